// File: rtl/dt_stage.sv
// Data-transfer stage between execute and memory: holds one instruction and
// issues exactly one data-cache request for it, stalling until the cache accepts.
module dt_stage #(
  parameter int ES_TO_DT_BUS_WD = 340,
  parameter int DT_TO_MS_BUS_WD = 272
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic [5:0]                 stall,
  output logic                       stallreq_dts,
  input  logic [ES_TO_DT_BUS_WD-1:0] es_to_dts_bus,
  output logic [DT_TO_MS_BUS_WD-1:0] dts_to_ms_bus,
  output logic                       data_sram_req,
  output logic                       data_sram_wr,
  output logic [3:0]                 data_sram_wstrb,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata,
  input  logic                       data_sram_addr_ok,
  output logic                       dts_fwd_we,
  output logic [4:0]                 dts_fwd_dest,
  output logic [31:0]                dts_fwd_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACPT = 2'd2
  } state_t;

  logic [ES_TO_DT_BUS_WD-1:0] r_bus;
  state_t                     r_state;
  state_t                     w_next_state;
  logic                       w_bubble;
  logic                       w_load;
  logic                       w_unused;

  assign w_bubble = stall[2] & ~stall[3];
  assign w_load   = ~stall[2];
  assign w_unused = ^{stall[5:4], stall[1:0], r_bus[339]};

  // Register update shares its priority with the FSM so the two never disagree.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bus <= '0;
    end else if (flush || w_bubble) begin
      r_bus <= '0;
    end else if (w_load) begin
      r_bus <= es_to_dts_bus;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (flush || w_bubble) begin
      w_next_state = IDLE;
    end else if (w_load) begin
      w_next_state = es_to_dts_bus[339] ? WAIT : IDLE;
    end else if (r_state == WAIT && data_sram_addr_ok) begin
      // ACPT is sticky until the next load so the request is never reissued.
      w_next_state = ACPT;
    end
  end

  assign data_sram_req   = (r_state == WAIT) & ~flush;
  assign data_sram_wr    = |r_bus[338:335];
  assign data_sram_wstrb = r_bus[338:335];
  assign data_sram_addr  = r_bus[334:303];
  assign data_sram_wdata = r_bus[302:271];
  assign stallreq_dts    = (r_state == WAIT) & ~data_sram_addr_ok;

  assign dts_to_ms_bus   = {(r_state == ACPT), r_bus[270:0]};

  assign dts_fwd_we      = r_bus[133] & (r_bus[142:137] == 6'd0);
  assign dts_fwd_dest    = r_bus[132:128];
  assign dts_fwd_result  = r_bus[127:96];

endmodule

// File: tb/tb_dt_stage.sv
// Directed bench for dt_stage: reset, load/store handshakes, flush, forwarding,
// bubble/hold behaviour and asynchronous reset.
module tb_dt_stage;

  logic         clk;
  logic         resetn;
  logic         flush;
  logic [5:0]   stall;
  logic         stallreq_dts;
  logic [339:0] es_to_dts_bus;
  logic [271:0] dts_to_ms_bus;
  logic         data_sram_req;
  logic         data_sram_wr;
  logic [3:0]   data_sram_wstrb;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         data_sram_addr_ok;
  logic         dts_fwd_we;
  logic [4:0]   dts_fwd_dest;
  logic [31:0]  dts_fwd_result;

  int tests;
  int fails;

  dt_stage #(.ES_TO_DT_BUS_WD(340), .DT_TO_MS_BUS_WD(272)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .flush             (flush),
    .stall             (stall),
    .stallreq_dts      (stallreq_dts),
    .es_to_dts_bus     (es_to_dts_bus),
    .dts_to_ms_bus     (dts_to_ms_bus),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .dts_fwd_we        (dts_fwd_we),
    .dts_fwd_dest      (dts_fwd_dest),
    .dts_fwd_result    (dts_fwd_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [339:0] mk(input logic en, input logic [3:0] we,
                                      input logic [31:0] addr, input logic [31:0] wd,
                                      input logic rwe, input logic [4:0] dst,
                                      input logic [31:0] res, input logic [5:0] lop);
    logic [339:0] b;
    b = '0;
    b[339]     = en;
    b[338:335] = we;
    b[334:303] = addr;
    b[302:271] = wd;
    b[142:137] = lop;
    b[133]     = rwe;
    b[132:128] = dst;
    b[127:96]  = res;
    return b;
  endfunction

  // Inputs change right after the falling edge; checks happen #1 later.
  task automatic drive(input logic fl, input logic [5:0] st, input logic [339:0] bus,
                       input logic ok);
    @(negedge clk);
    flush = fl;
    stall = st;
    es_to_dts_bus = bus;
    data_sram_addr_ok = ok;
    #1;
  endtask

  task automatic test_reset;
    logic [339:0] b;
    b = mk(1'b1, 4'b1111, 32'hAAAA_0000, 32'h5555_5555, 1'b1, 5'd7, 32'h99, 6'd0);
    resetn = 1'b0;
    drive(1'b0, 6'b000000, b, 1'b1);
    drive(1'b0, 6'b000000, b, 1'b1);
    tests++; if (data_sram_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", data_sram_req); end
    tests++; if (stallreq_dts !== 1'b0) begin fails++; $display("FAIL reset_stallreq got %b exp 0", stallreq_dts); end
    tests++; if (dts_fwd_we !== 1'b0) begin fails++; $display("FAIL reset_fwd_we got %b exp 0", dts_fwd_we); end
    tests++; if (dts_to_ms_bus !== 272'd0) begin fails++; $display("FAIL reset_ms_bus got %h exp 0", dts_to_ms_bus); end
    tests++; if ({data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata} !== 69'd0) begin
      fails++; $display("FAIL reset_sram_bus got %b/%h/%h/%h exp 0", data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata); end
    drive(1'b0, 6'b000000, '0, 1'b0);
    resetn = 1'b1;
    drive(1'b0, 6'b000000, '0, 1'b0);
  endtask

  task automatic test_load;
    logic [339:0] b;
    int req_cycles;
    int stallreq_seen;
    b = mk(1'b1, 4'b0000, 32'h1000_0004, 32'h0, 1'b1, 5'd9, 32'h0, 6'b000001);
    req_cycles = 0;
    stallreq_seen = 0;
    drive(1'b0, 6'b000000, b, 1'b1);
    stallreq_seen += int'(stallreq_dts);
    drive(1'b0, 6'b001100, '0, 1'b1);
    req_cycles += int'(data_sram_req);
    stallreq_seen += int'(stallreq_dts);
    tests++; if (data_sram_wr !== 1'b0) begin fails++; $display("FAIL load_wr got %b exp 0", data_sram_wr); end
    tests++; if (data_sram_addr !== 32'h1000_0004) begin fails++; $display("FAIL load_addr got %h exp 10000004", data_sram_addr); end
    tests++; if (dts_fwd_we !== 1'b0) begin fails++; $display("FAIL load_fwd_we got %b exp 0", dts_fwd_we); end
    drive(1'b0, 6'b001100, '0, 1'b1);
    req_cycles += int'(data_sram_req);
    stallreq_seen += int'(stallreq_dts);
    tests++; if (dts_to_ms_bus !== {1'b1, b[270:0]}) begin fails++; $display("FAIL load_mem_issued got %h exp %h", dts_to_ms_bus, {1'b1, b[270:0]}); end
    drive(1'b0, 6'b001100, '0, 1'b1);
    req_cycles += int'(data_sram_req);
    stallreq_seen += int'(stallreq_dts);
    tests++; if (req_cycles !== 1) begin fails++; $display("FAIL load_req_cycles got %0d exp 1", req_cycles); end
    tests++; if (stallreq_seen !== 0) begin fails++; $display("FAIL load_stallreq got %0d exp 0", stallreq_seen); end
  endtask

  task automatic test_store;
    logic [339:0] b;
    int accepted;
    b = mk(1'b1, 4'b0011, 32'h2000_0008, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 6'd0);
    accepted = 0;
    drive(1'b0, 6'b000000, b, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 6'b001100, '0, 1'b0);
      tests++; if ({data_sram_req, stallreq_dts} !== 2'b11) begin
        fails++; $display("FAIL store_wait%0d req/stallreq got %b%b exp 11", i, data_sram_req, stallreq_dts); end
      tests++; if ({data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata} !== {1'b1, 4'b0011, 32'h2000_0008, 32'hDEAD_BEEF}) begin
        fails++; $display("FAIL store_stable%0d got %b/%b/%h/%h", i, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata); end
    end
    drive(1'b0, 6'b001100, '0, 1'b1);
    accepted += int'(data_sram_req & data_sram_addr_ok);
    tests++; if (stallreq_dts !== 1'b0) begin fails++; $display("FAIL store_accept_stallreq got %b exp 0", stallreq_dts); end
    // ACPT with addr_ok still high and stage held: no second request.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 6'b001100, '0, 1'b1);
      accepted += int'(data_sram_req & data_sram_addr_ok);
      tests++; if (dts_to_ms_bus[271] !== 1'b1) begin fails++; $display("FAIL store_acpt_hold%0d mem_issued got %b exp 1", i, dts_to_ms_bus[271]); end
    end
    tests++; if (accepted !== 1) begin fails++; $display("FAIL store_accepted got %0d exp 1", accepted); end
    tests++; if (dts_to_ms_bus !== {1'b1, b[270:0]}) begin fails++; $display("FAIL store_hold_bus got %h exp %h", dts_to_ms_bus, {1'b1, b[270:0]}); end
    drive(1'b0, 6'b000100, '0, 1'b0);
    drive(1'b0, 6'b000000, '0, 1'b0);
    tests++; if ({dts_to_ms_bus, data_sram_wr, data_sram_addr} !== 305'd0) begin
      fails++; $display("FAIL bubble_clear got %h/%b/%h exp 0", dts_to_ms_bus, data_sram_wr, data_sram_addr); end
  endtask

  task automatic test_flush;
    logic [339:0] b;
    b = mk(1'b1, 4'b1111, 32'h3000_0010, 32'h0BAD_F00D, 1'b1, 5'd3, 32'h77, 6'd0);
    drive(1'b0, 6'b000000, b, 1'b0);
    drive(1'b0, 6'b001100, '0, 1'b0);
    tests++; if (data_sram_req !== 1'b1) begin fails++; $display("FAIL flush_wait1_req got %b exp 1", data_sram_req); end
    drive(1'b1, 6'b001100, '0, 1'b1);
    tests++; if (data_sram_req !== 1'b0) begin fails++; $display("FAIL flush_req_drop got %b exp 0", data_sram_req); end
    drive(1'b0, 6'b001100, '0, 1'b0);
    tests++; if ({dts_to_ms_bus, data_sram_req, stallreq_dts, data_sram_addr} !== 306'd0) begin
      fails++; $display("FAIL flush_clear got %h/%b%b/%h exp 0", dts_to_ms_bus, data_sram_req, stallreq_dts, data_sram_addr); end
    drive(1'b0, 6'b001100, '0, 1'b1);
    drive(1'b0, 6'b001100, '0, 1'b1);
    tests++; if ({dts_to_ms_bus[271], data_sram_req} !== 2'b00) begin
      fails++; $display("FAIL idle_ignore_ok got %b%b exp 00", dts_to_ms_bus[271], data_sram_req); end
  endtask

  task automatic test_forward;
    drive(1'b0, 6'b000000, mk(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 5'd5, 32'h0000_1234, 6'd0), 1'b0);
    drive(1'b0, 6'b000000, mk(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 5'd5, 32'h0000_1234, 6'b000100), 1'b0);
    tests++; if ({dts_fwd_we, dts_fwd_dest, dts_fwd_result} !== {1'b1, 5'd5, 32'h0000_1234}) begin
      fails++; $display("FAIL fwd_alu got %b/%0d/%h exp 1/5/00001234", dts_fwd_we, dts_fwd_dest, dts_fwd_result); end
    tests++; if ({data_sram_req, dts_to_ms_bus[271]} !== 2'b00) begin
      fails++; $display("FAIL fwd_alu_noreq got %b%b exp 00", data_sram_req, dts_to_ms_bus[271]); end
    drive(1'b0, 6'b000000, '0, 1'b0);
    tests++; if ({dts_fwd_we, dts_fwd_dest, dts_fwd_result} !== {1'b0, 5'd5, 32'h0000_1234}) begin
      fails++; $display("FAIL fwd_load got %b/%0d/%h exp 0/5/00001234", dts_fwd_we, dts_fwd_dest, dts_fwd_result); end
    drive(1'b0, 6'b000000, '0, 1'b0);
  endtask

  task automatic test_async_reset;
    logic [339:0] b;
    b = mk(1'b1, 4'b0001, 32'h4000_0000, 32'h1111_2222, 1'b1, 5'd1, 32'h1, 6'd0);
    drive(1'b0, 6'b000000, b, 1'b0);
    drive(1'b0, 6'b001100, '0, 1'b0);
    tests++; if (data_sram_req !== 1'b1) begin fails++; $display("FAIL async_pre_req got %b exp 1", data_sram_req); end
    resetn = 1'b0;
    #1;
    tests++; if ({data_sram_req, stallreq_dts, dts_fwd_we, data_sram_addr} !== 35'd0) begin
      fails++; $display("FAIL async_drop got %b%b%b/%h exp 0", data_sram_req, stallreq_dts, dts_fwd_we, data_sram_addr); end
    drive(1'b0, 6'b000000, b, 1'b0);
    resetn = 1'b1;
    #1;
    tests++; if (data_sram_req !== 1'b0) begin fails++; $display("FAIL release_no_edge got %b exp 0", data_sram_req); end
    drive(1'b0, 6'b001100, '0, 1'b0);
    tests++; if ({data_sram_req, data_sram_addr} !== {1'b1, 32'h4000_0000}) begin
      fails++; $display("FAIL release_first_edge got %b/%h exp 1/40000000", data_sram_req, data_sram_addr); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    resetn = 1'b0;
    flush = 1'b0;
    stall = 6'd0;
    es_to_dts_bus = '0;
    data_sram_addr_ok = 1'b0;
    test_reset();
    test_load();
    test_store();
    test_flush();
    test_forward();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
